cache_axi_arbiter: RTL and testbench
====================================

Name: cache_axi_arbiter

Overview:
- Merges the icache and dcache AXI master ports into one AXI master port toward the bus or memory.
- Reads: shared, one burst in flight at a time, round-robin between icache and dcache.
- Writes: dcache only, at most one outstanding.
- Read-after-write ordering: a dcache read is never granted while a dcache write awaits its B response.

Parameters:
ADDR_W, 32, address width of all ar/aw channels
DATA_W, 32, data width of r/w channels

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
i_araddr/i_arlen/i_arsize/i_arvalid  input  ADDR_W/8/3/1  icache read request
i_arready  output  1  icache read address accepted
i_rdata/i_rlast/i_rvalid  output  DATA_W/1/1  icache read data
i_rready  input  1  icache read data ready
d_araddr/d_arlen/d_arsize/d_arvalid  input  ADDR_W/8/3/1  dcache read request
d_arready  output  1  dcache read address accepted
d_rdata/d_rlast/d_rvalid  output  DATA_W/1/1  dcache read data
d_rready  input  1  dcache read data ready
d_awaddr/d_awlen/d_awsize/d_awvalid  input  ADDR_W/8/3/1  dcache write address
d_awready  output  1  dcache write address accepted
d_wdata/d_wstrb/d_wlast/d_wvalid  input  DATA_W/4/1/1  dcache write data
d_wready  output  1  dcache write data ready
d_bvalid  output  1  dcache write response
d_bready  input  1  dcache write response ready
m_araddr/m_arlen/m_arsize/m_arvalid  output  ADDR_W/8/3/1  merged read address
m_arready  input  1  merged read address ready
m_rdata/m_rlast/m_rvalid  input  DATA_W/1/1  merged read data
m_rready  output  1  merged read data ready
m_awaddr/m_awlen/m_awsize/m_awvalid  output  ADDR_W/8/3/1  merged write address
m_awready  input  1  merged write address ready
m_wdata/m_wstrb/m_wlast/m_wvalid  output  DATA_W/4/1/1  merged write data
m_wready  input  1  merged write data ready
m_bvalid  input  1  merged write response
m_bready  output  1  merged write response ready

Behaviour:
- Reset: async, active-high. Read FSM=R_IDLE; owner=I; last_grant=I; wr_busy=0; m_arvalid=0; i_arready=d_arready=0; i_rvalid=d_rvalid=0; m_rready=0. Write outputs are pure pass-through gated by wr_busy.
- Read FSM states R_IDLE, R_ADDR, R_DATA.
- R_IDLE, arbitration:
  - d_ok = d_arvalid && !wr_busy.
  - If d_ok and i_arvalid both hold, grant the requester that is not last_grant. Otherwise grant whichever is eligible.
  - On grant, in the same cycle: assert the winner's arready (one-cycle pulse); latch addr/len/size into registers; set owner and last_grant; go to R_ADDR.
  - No grant: stay in R_IDLE.
- R_ADDR: m_arvalid=1, driven from registers. On m_arready go to R_DATA. Requester arready stays 0.
- R_DATA:
  - m_rready = owner's rready. Owner's rvalid/rlast = m_rvalid/m_rlast; non-owner's rvalid=0. rdata is broadcast to both.
  - On m_rvalid && m_rready && m_rlast, go to R_IDLE.
- Read latency: grant-to-m_arvalid is 1 cycle. Back-to-back bursts have 1 idle cycle (R_IDLE) between rlast and the next grant.
- Write tracking: wr_busy sets on m_awvalid && m_awready and clears on m_bvalid && m_bready. If both occur in the same cycle, set wins.
  - m_awvalid = d_awvalid && !wr_busy.
  - d_awready = m_awready && !wr_busy.
- W and B channels pass straight through, combinationally: m_w* = d_w*, d_wready = m_wready, d_bvalid = m_bvalid, m_bready = d_bready.
- A dcache read pending while wr_busy=1 waits; icache reads may be granted meanwhile.
- A read already granted to the dcache is unaffected by a later write.
- Reset mid-burst: FSM returns to R_IDLE immediately; in-flight beats are dropped. The slave is reset by the same rst.
- arlen/arsize are forwarded unmodified; the arbiter does no beat counting and trusts rlast.

Decomposition:
- Shared package cache_axi_pkg holds:
  - read FSM state enum (R_IDLE, R_ADDR, R_DATA);
  - owner encoding (OWN_I=0, OWN_D=1);
  - AXI size constant SIZE_4B=3'd2.
- No sub-module; the write tracker is a single flop inside this block.

Test Plan:
- icache only: i_arvalid, addr 0x1FC00000, arlen=7 -> i_arready pulse; m_arvalid next cycle with the same addr; 8 beats routed to i_r*, i_rlast on beat 8; d_rvalid stays 0.
- Both requesters in the same cycle after reset (last_grant=I) -> dcache granted first; after its rlast, icache granted; third simultaneous request goes to dcache again.
- Write then read: dcache aw 0x80001000 accepted, then d_arvalid 0x80001000 -> no d_arready until the cycle after m_bvalid && m_bready.
- icache read during wr_busy -> granted normally and completes while the write's B is pending.
- m_rready backpressure: owner deasserts rready for 3 cycles mid-burst -> m_rready follows; no beat lost or duplicated; FSM stays in R_DATA.
- rst asserted mid-burst in R_DATA -> m_arvalid, all rvalid and all arready are 0 asynchronously; after release, a new request is granted normally.

Source files
------------

// File: rtl/cache_axi_pkg.sv
// Shared types for the cache-to-AXI arbiter: read FSM states, read owner
// encoding and the AXI size code used by the caches.
package cache_axi_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [2:0] SIZE_4B = 3'd2;

endpackage

// File: rtl/cache_axi_arbiter.sv
// Merges icache and dcache AXI masters onto one AXI master: round-robin
// single-burst reads, dcache-only single-outstanding writes, read-after-write safe.
module cache_axi_arbiter
  import cache_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // icache read
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic [7:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  input  logic                i_arvalid,
  output logic                i_arready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rlast,
  output logic                i_rvalid,
  input  logic                i_rready,
  // dcache read
  input  logic [ADDR_W-1:0]   d_araddr,
  input  logic [7:0]          d_arlen,
  input  logic [2:0]          d_arsize,
  input  logic                d_arvalid,
  output logic                d_arready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rlast,
  output logic                d_rvalid,
  input  logic                d_rready,
  // dcache write
  input  logic [ADDR_W-1:0]   d_awaddr,
  input  logic [7:0]          d_awlen,
  input  logic [2:0]          d_awsize,
  input  logic                d_awvalid,
  output logic                d_awready,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic                d_wlast,
  input  logic                d_wvalid,
  output logic                d_wready,
  output logic                d_bvalid,
  input  logic                d_bready,
  // merged master
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic                m_bvalid,
  output logic                m_bready
);

  rd_state_e          state_q, state_d;
  owner_e             owner_q, last_grant_q;
  logic               wr_busy_q;
  logic               d_ok, grant_i, grant_d, in_data, own_d;
  logic [ADDR_W-1:0]  ar_addr_q;
  logic [7:0]         ar_len_q;
  logic [2:0]         ar_size_q;

  // Arbitration; gated by rst so arready drops asynchronously with reset.
  always_comb begin
    d_ok    = d_arvalid && !wr_busy_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == R_IDLE && !rst) begin
      if (d_ok && i_arvalid) begin
        if (last_grant_q == OWN_I) grant_d = 1'b1;
        else                       grant_i = 1'b1;
      end else if (d_ok) begin
        grant_d = 1'b1;
      end else if (i_arvalid) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:  if (grant_i || grant_d) state_d = R_ADDR;
      R_ADDR:  if (m_arready) state_d = R_DATA;
      R_DATA:  if (m_rvalid && m_rready && m_rlast) state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= R_IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      wr_busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        owner_q      <= OWN_D;
        last_grant_q <= OWN_D;
      end else if (grant_i) begin
        owner_q      <= OWN_I;
        last_grant_q <= OWN_I;
      end
      // A new AW acceptance wins over a same-cycle B completion.
      if (m_awvalid && m_awready)   wr_busy_q <= 1'b1;
      else if (m_bvalid && m_bready) wr_busy_q <= 1'b0;
    end
  end

  // Address/len/size capture carries no reset; it is only read after a grant.
  always_ff @(posedge clk) begin
    if (grant_d) begin
      ar_addr_q <= d_araddr;
      ar_len_q  <= d_arlen;
      ar_size_q <= d_arsize;
    end else if (grant_i) begin
      ar_addr_q <= i_araddr;
      ar_len_q  <= i_arlen;
      ar_size_q <= i_arsize;
    end
  end

  assign i_arready = grant_i;
  assign d_arready = grant_d;

  assign m_araddr  = ar_addr_q;
  assign m_arlen   = ar_len_q;
  assign m_arsize  = ar_size_q;
  assign m_arvalid = (state_q == R_ADDR);

  assign in_data  = (state_q == R_DATA);
  assign own_d    = (owner_q == OWN_D);
  assign m_rready = in_data && (own_d ? d_rready : i_rready);
  assign i_rvalid = in_data && !own_d && m_rvalid;
  assign d_rvalid = in_data &&  own_d && m_rvalid;
  assign i_rlast  = in_data && !own_d && m_rlast;
  assign d_rlast  = in_data &&  own_d && m_rlast;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

  assign m_awaddr  = d_awaddr;
  assign m_awlen   = d_awlen;
  assign m_awsize  = d_awsize;
  assign m_awvalid = d_awvalid && !wr_busy_q;
  assign d_awready = m_awready && !wr_busy_q;

  assign m_wdata  = d_wdata;
  assign m_wstrb  = d_wstrb;
  assign m_wlast  = d_wlast;
  assign m_wvalid = d_wvalid;
  assign d_wready = m_wready;
  assign d_bvalid = m_bvalid;
  assign m_bready = d_bready;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Self-checking bench for cache_axi_arbiter: directed sequences, vector tables
// and randomized bursts scored against a rule-level arbitration model.
module tb_cache_axi_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] i_araddr, d_araddr, d_awaddr, m_araddr, m_awaddr;
  logic [7:0]        i_arlen, d_arlen, d_awlen, m_arlen, m_awlen;
  logic [2:0]        i_arsize, d_arsize, d_awsize, m_arsize, m_awsize;
  logic              i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
  logic              d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
  logic [DATA_W-1:0] i_rdata, d_rdata, d_wdata, m_rdata, m_wdata;
  logic              d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bvalid, d_bready;
  logic [3:0]        d_wstrb, m_wstrb;
  logic              m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic              m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
    .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
    .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid),
    .d_awready(d_awready), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
    .d_wvalid(d_wvalid), .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awvalid(m_awvalid),
    .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  typedef struct {
    bit iv; bit dv; bit ei; bit ed;
  } arb_vec_t;

  typedef struct {
    bit awv; bit awr; bit wv; logic [31:0] wd; logic [3:0] ws; bit wl; bit wr; bit bv; bit br;
    bit e_awv; bit e_awr;
  } wr_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    i_arvalid = 0; d_arvalid = 0; i_rready = 0; d_rready = 0;
    d_awvalid = 0; d_wvalid = 0; d_bready = 0; d_wlast = 0;
    m_arready = 0; m_rvalid = 0; m_rlast = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic request(input bit iv, input bit dv, input logic [31:0] ia, input logic [31:0] da,
                         input logic [7:0] il, input logic [7:0] dl, input bit ei, input bit ed);
    @(negedge clk);
    i_arvalid = iv; i_araddr = ia; i_arlen = il; i_arsize = 3'd2;
    d_arvalid = dv; d_araddr = da; d_arlen = dl; d_arsize = 3'd2;
    #1;
    chk("i_arready", i_arready, ei);
    chk("d_arready", d_arready, ed);
    @(posedge clk);
    #1;
    i_arvalid = 0; d_arvalid = 0;
  endtask

  // Runs address and data phases of a burst that was granted at the last edge.
  task automatic do_burst(input bit own_d, input logic [31:0] addr, input logic [7:0] len,
                          input int stall_beat);
    logic [31:0] beat_data [$];
    int got, stall_left, cyc;
    bit rr, lst;
    @(negedge clk);
    #1;
    chk("m_arvalid", m_arvalid, 1);
    chk("m_araddr", m_araddr, addr);
    chk("m_arlen", m_arlen, len);
    chk("m_arsize", m_arsize, 3'd2);
    m_arready = 1;
    @(posedge clk);
    #1;
    m_arready = 0;
    for (int k = 0; k <= int'(len); k++) beat_data.push_back($urandom);
    got = 0; stall_left = 3; cyc = 0;
    while (got <= int'(len) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      lst = (got == int'(len));
      m_rvalid = 1; m_rdata = beat_data[got]; m_rlast = lst;
      if (stall_beat >= 0) begin
        rr = !(got == stall_beat && stall_left > 0);
        if (!rr) stall_left--;
      end else begin
        rr = ($urandom_range(0, 3) != 0);
      end
      i_rready = own_d ? 1'($urandom_range(0, 1)) : rr;
      d_rready = own_d ? rr : 1'($urandom_range(0, 1));
      #1;
      chk("m_rready", m_rready, rr);
      chk("own_rvalid", own_d ? d_rvalid : i_rvalid, 1);
      chk("other_rvalid", own_d ? i_rvalid : d_rvalid, 0);
      chk("own_rlast", own_d ? d_rlast : i_rlast, lst);
      chk("own_rdata", own_d ? d_rdata : i_rdata, beat_data[got]);
      chk("m_arvalid_in_data", m_arvalid, 0);
      if (rr) got++;
    end
    if (got <= int'(len)) chk("burst_timeout_beats", got, int'(len) + 1);
    @(negedge clk);
    m_rvalid = 0; m_rlast = 0; i_rready = 0; d_rready = 0;
  endtask

  task automatic do_aw(input logic [31:0] addr, input bit exp_acc);
    @(negedge clk);
    d_awvalid = 1; d_awaddr = addr; d_awlen = 8'd0; d_awsize = 3'd2; m_awready = 1;
    #1;
    chk("m_awvalid", m_awvalid, exp_acc);
    chk("d_awready", d_awready, exp_acc);
    chk("m_awaddr", m_awaddr, addr);
    @(posedge clk);
    #1;
    d_awvalid = 0; m_awready = 0;
  endtask

  task automatic do_b();
    @(negedge clk);
    m_bvalid = 1; d_bready = 1;
    #1;
    chk("d_bvalid", d_bvalid, 1);
    chk("m_bready", m_bready, 1);
    @(posedge clk);
    #1;
    m_bvalid = 0; d_bready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    arb_vec_t arb_tab [7];
    wr_vec_t  wr_tab [4];
    bit model_last_d, model_wb, iv, dv, dok, win_d;
    logic [31:0] ia, da;
    logic [7:0]  il, dl;

    arb_tab[0] = '{1, 1, 0, 1};
    arb_tab[1] = '{1, 1, 1, 0};
    arb_tab[2] = '{1, 1, 0, 1};
    arb_tab[3] = '{1, 0, 1, 0};
    arb_tab[4] = '{0, 1, 0, 1};
    arb_tab[5] = '{1, 1, 1, 0};
    arb_tab[6] = '{0, 0, 0, 0};

    wr_tab[0] = '{1, 0, 1, 32'hA5A5A5A5, 4'hF, 1, 0, 0, 1, 1, 0};
    wr_tab[1] = '{0, 1, 0, 32'h12345678, 4'h3, 0, 1, 1, 0, 0, 1};
    wr_tab[2] = '{1, 1, 1, 32'hDEADBEEF, 4'hC, 1, 1, 1, 1, 1, 1};
    wr_tab[3] = '{0, 0, 0, 32'h00000000, 4'h0, 0, 0, 0, 0, 0, 0};

    // Reset held: everything quiet even with requests and read data present.
    rst = 1'b1;
    clear_inputs();
    i_araddr = '0; i_arlen = '0; i_arsize = 3'd2;
    d_araddr = '0; d_arlen = '0; d_arsize = 3'd2;
    d_awaddr = '0; d_awlen = '0; d_awsize = 3'd2; d_wdata = '0; d_wstrb = '0;
    m_rdata = '0;
    i_arvalid = 1; d_arvalid = 1; m_rvalid = 1; i_rready = 1; d_rready = 1;
    #2;
    chk("rst_i_arready", i_arready, 0);
    chk("rst_d_arready", d_arready, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;

    // icache-only 8-beat burst from the boot vector.
    request(1, 0, 32'h1FC00000, 32'h0, 8'd7, 8'd0, 1, 0);
    do_burst(0, 32'h1FC00000, 8'd7, -1);

    // Arbitration table; last grant is icache entering it.
    for (int t = 0; t < 7; t++) begin
      ia = $urandom; da = $urandom;
      request(arb_tab[t].iv, arb_tab[t].dv, ia, da, 8'd1, 8'd2, arb_tab[t].ei, arb_tab[t].ed);
      if (arb_tab[t].ed)      do_burst(1, da, 8'd2, -1);
      else if (arb_tab[t].ei) do_burst(0, ia, 8'd1, -1);
    end

    // Write-side pass-through table with no write outstanding.
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      d_awaddr = 32'h80002000 + 32'(t); d_awvalid = wr_tab[t].awv; m_awready = wr_tab[t].awr;
      d_wvalid = wr_tab[t].wv; d_wdata = wr_tab[t].wd; d_wstrb = wr_tab[t].ws;
      d_wlast = wr_tab[t].wl; m_wready = wr_tab[t].wr; m_bvalid = wr_tab[t].bv;
      d_bready = wr_tab[t].br;
      #1;
      chk("tab_m_awvalid", m_awvalid, wr_tab[t].e_awv);
      chk("tab_d_awready", d_awready, wr_tab[t].e_awr);
      chk("tab_m_awaddr", m_awaddr, 32'h80002000 + 32'(t));
      chk("tab_m_wvalid", m_wvalid, wr_tab[t].wv);
      chk("tab_m_wdata", m_wdata, wr_tab[t].wd);
      chk("tab_m_wstrb", m_wstrb, wr_tab[t].ws);
      chk("tab_m_wlast", m_wlast, wr_tab[t].wl);
      chk("tab_d_wready", d_wready, wr_tab[t].wr);
      chk("tab_d_bvalid", d_bvalid, wr_tab[t].bv);
      chk("tab_m_bready", m_bready, wr_tab[t].br);
      #1;
      clear_inputs();
    end

    // Read-after-write: dcache read held off until B completes; icache proceeds.
    do_aw(32'h80001000, 1);
    do_aw(32'h80001040, 0);
    @(negedge clk);
    d_arvalid = 1; d_araddr = 32'h80001000; d_arlen = 8'd1; d_arsize = 3'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("raw_d_arready_blocked", d_arready, 0);
      @(negedge clk);
    end
    i_arvalid = 1; i_araddr = 32'h1FC00100; i_arlen = 8'd3; i_arsize = 3'd2;
    #1;
    chk("raw_i_arready", i_arready, 1);
    chk("raw_d_arready", d_arready, 0);
    @(posedge clk);
    #1;
    i_arvalid = 0;
    do_burst(0, 32'h1FC00100, 8'd3, -1);
    #1;
    chk("raw_d_still_blocked", d_arready, 0);
    @(negedge clk);
    m_bvalid = 1; d_bready = 1;
    #1;
    chk("raw_b_cycle_d_arready", d_arready, 0);
    @(posedge clk);
    #1;
    m_bvalid = 0; d_bready = 0;
    @(negedge clk);
    #1;
    chk("raw_after_b_d_arready", d_arready, 1);
    @(posedge clk);
    #1;
    d_arvalid = 0;
    do_burst(1, 32'h80001000, 8'd1, -1);

    // Owner backpressure for 3 cycles mid-burst.
    request(0, 1, 32'h0, 32'h80003000, 8'd0, 8'd5, 0, 1);
    do_burst(1, 32'h80003000, 8'd5, 2);

    // Reset in the middle of the data phase.
    request(1, 0, 32'h00001000, 32'h0, 8'd3, 8'd0, 1, 0);
    @(negedge clk);
    m_arready = 1;
    @(posedge clk);
    #1;
    m_arready = 0;
    @(negedge clk);
    m_rvalid = 1; m_rdata = 32'hCAFE0001; i_rready = 1; i_arvalid = 1; d_arvalid = 1;
    #1;
    chk("mid_i_rvalid", i_rvalid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_m_arvalid", m_arvalid, 0);
    chk("mid_rst_i_rvalid", i_rvalid, 0);
    chk("mid_rst_d_rvalid", d_rvalid, 0);
    chk("mid_rst_m_rready", m_rready, 0);
    chk("mid_rst_i_arready", i_arready, 0);
    chk("mid_rst_d_arready", d_arready, 0);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    request(1, 1, 32'h00002000, 32'h80004000, 8'd1, 8'd1, 0, 1);
    do_burst(1, 32'h80004000, 8'd1, -1);

    // Randomized traffic against the arbitration rules.
    do_reset();
    model_last_d = 0;
    model_wb = 0;
    for (int it = 0; it < 40; it++) begin
      if (!model_wb && $urandom_range(0, 2) == 0) begin
        do_aw($urandom, 1);
        model_wb = 1;
      end else if (model_wb && $urandom_range(0, 3) == 0) begin
        do_aw($urandom, 0);
      end
      iv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      dok = dv && !model_wb;
      if (!iv && !dok) iv = 1;
      win_d = (dok && iv) ? !model_last_d : dok;
      model_last_d = win_d;
      ia = $urandom; da = $urandom;
      il = 8'($urandom_range(0, 5));
      dl = 8'($urandom_range(0, 5));
      request(iv, dv, ia, da, il, dl, !win_d, win_d);
      do_burst(win_d, win_d ? da : ia, win_d ? dl : il, -1);
      if (model_wb && $urandom_range(0, 1) == 1) begin
        do_b();
        model_wb = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
